// File: rtl/dmem_bank_arbiter.sv
// Round-robin arbiter for one shared single-port data-memory bank.
// It grants a whole strided burst to one requester and tags load returns to that owner.
module dmem_bank_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 10,
   parameter int LEN_W   = 8,
   parameter int RD_LAT  = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        I_Req,
   input  logic [NUM_REQ-1:0]        I_St,
   input  logic [NUM_REQ*ADDR_W-1:0] I_Base,
   input  logic [NUM_REQ*LEN_W-1:0]  I_Len,
   input  logic [NUM_REQ*ADDR_W-1:0] I_Stride,
   input  logic                      I_Stall,
   output logic [NUM_REQ-1:0]        O_Grant,
   output logic                      O_Mem_En,
   output logic                      O_Mem_We,
   output logic [ADDR_W-1:0]         O_Mem_Addr,
   output logic [NUM_REQ-1:0]        O_Ld_Valid,
   output logic [NUM_REQ-1:0]        O_Done,
   output logic                      O_Busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(RD_LAT + 1);
   localparam logic [IDX_W:0] NREQ_W = (IDX_W + 1)'(NUM_REQ);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BURST,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t             state_reg,  state_next;
   logic [IDX_W-1:0]   owner_reg,  owner_next;
   logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
   logic               st_reg,     st_next;
   logic [ADDR_W-1:0]  addr_reg,   addr_next;
   logic [ADDR_W-1:0]  stride_reg, stride_next;
   logic [LEN_W-1:0]   rem_reg,    rem_next;
   logic [CNT_W-1:0]   drain_reg,  drain_next;
   logic [RD_LAT-1:0]  ld_pipe_reg, ld_pipe_next;

   logic [ADDR_W-1:0]  base_arr   [NUM_REQ];
   logic [ADDR_W-1:0]  stride_arr [NUM_REQ];
   logic [LEN_W-1:0]   len_arr    [NUM_REQ];

   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W:0]     cand;
   logic [NUM_REQ-1:0] owner_onehot;
   logic               mem_en;
   logic               mem_we;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign base_arr[gi]   = I_Base[gi*ADDR_W +: ADDR_W];
         assign stride_arr[gi] = I_Stride[gi*ADDR_W +: ADDR_W];
         assign len_arr[gi]    = I_Len[gi*LEN_W +: LEN_W];
      end
   endgenerate

   // First requester strictly after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr_reg} + (IDX_W + 1)'(k);
         if (cand >= NREQ_W) begin
            cand = cand - NREQ_W;
         end
         if (!pick_valid && I_Req[cand[IDX_W-1:0]]) begin
            pick_valid = 1'b1;
            pick_idx   = cand[IDX_W-1:0];
         end
      end
   end

   assign owner_onehot = NUM_REQ'(1) << owner_reg;

   always_comb begin
      state_next  = state_reg;
      owner_next  = owner_reg;
      rr_ptr_next = rr_ptr_reg;
      st_next     = st_reg;
      addr_next   = addr_reg;
      stride_next = stride_reg;
      rem_next    = rem_reg;
      drain_next  = drain_reg;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      O_Grant     = '0;
      O_Done      = '0;
      O_Mem_Addr  = '0;

      case (state_reg)
         ST_IDLE: begin
            if (pick_valid) begin
               owner_next  = pick_idx;
               st_next     = I_St[pick_idx];
               addr_next   = base_arr[pick_idx];
               stride_next = stride_arr[pick_idx];
               rem_next    = len_arr[pick_idx];
               state_next  = ST_BURST;
            end
         end

         ST_BURST: begin
            O_Grant = owner_onehot;
            if (rem_reg == '0) begin
               state_next = ST_DONE;
            end else begin
               O_Mem_Addr = addr_reg;
               if (!I_Stall) begin
                  mem_en    = 1'b1;
                  mem_we    = st_reg;
                  addr_next = addr_reg + stride_reg;
                  rem_next  = rem_reg - 1'b1;
                  if (rem_reg == LEN_W'(1)) begin
                     state_next = st_reg ? ST_DONE : ST_DRAIN;
                     drain_next = CNT_W'(RD_LAT - 1);
                  end
               end
            end
         end

         // Hold ownership until the last load word has come back.
         ST_DRAIN: begin
            O_Grant = owner_onehot;
            if (drain_reg == '0) begin
               state_next = ST_DONE;
            end else begin
               drain_next = drain_reg - 1'b1;
            end
         end

         ST_DONE: begin
            O_Grant     = owner_onehot;
            O_Done      = owner_onehot;
            rr_ptr_next = owner_reg;
            state_next  = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign O_Mem_En = mem_en;
   assign O_Mem_We = mem_we;
   assign O_Busy   = (state_reg != ST_IDLE);

   // Read-valid delay line: bit RD_LAT-1 marks a load word arriving this cycle.
   assign ld_pipe_next[0] = mem_en & ~mem_we;
   generate
      for (gi = 1; gi < RD_LAT; gi++) begin : g_ld_pipe
         assign ld_pipe_next[gi] = ld_pipe_reg[gi-1];
      end
   endgenerate

   assign O_Ld_Valid = ld_pipe_reg[RD_LAT-1] ? owner_onehot : '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         owner_reg   <= '0;
         rr_ptr_reg  <= IDX_W'(NUM_REQ - 1);
         st_reg      <= 1'b0;
         addr_reg    <= '0;
         stride_reg  <= '0;
         rem_reg     <= '0;
         drain_reg   <= '0;
         ld_pipe_reg <= '0;
      end else begin
         state_reg   <= state_next;
         owner_reg   <= owner_next;
         rr_ptr_reg  <= rr_ptr_next;
         st_reg      <= st_next;
         addr_reg    <= addr_next;
         stride_reg  <= stride_next;
         rem_reg     <= rem_next;
         drain_reg   <= drain_next;
         ld_pipe_reg <= ld_pipe_next;
      end
   end

endmodule

// File: tb/tb_dmem_bank_arbiter.sv
// Directed bench for dmem_bank_arbiter: cycle-by-cycle expectations for each burst scenario.
module tb_dmem_bank_arbiter;

   localparam int NUM_REQ = 3;
   localparam int ADDR_W  = 10;
   localparam int LEN_W   = 8;
   localparam int RD_LAT  = 2;

   logic                      clock = 1'b0;
   logic                      reset;
   logic [NUM_REQ-1:0]        I_Req;
   logic [NUM_REQ-1:0]        I_St;
   logic [NUM_REQ*ADDR_W-1:0] I_Base;
   logic [NUM_REQ*LEN_W-1:0]  I_Len;
   logic [NUM_REQ*ADDR_W-1:0] I_Stride;
   logic                      I_Stall;
   logic [NUM_REQ-1:0]        O_Grant;
   logic                      O_Mem_En;
   logic                      O_Mem_We;
   logic [ADDR_W-1:0]         O_Mem_Addr;
   logic [NUM_REQ-1:0]        O_Ld_Valid;
   logic [NUM_REQ-1:0]        O_Done;
   logic                      O_Busy;

   int checks = 0;
   int errors = 0;

   logic [ADDR_W-1:0]  t3_addr   [5] = '{10'h000, 10'h020, 10'h022, 10'h022, 10'h024};
   logic [NUM_REQ-1:0] order_exp [3] = '{3'b001, 3'b010, 3'b100};

   always #5 clock = ~clock;

   dmem_bank_arbiter #(
      .NUM_REQ(NUM_REQ),
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W),
      .RD_LAT (RD_LAT)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .I_Req     (I_Req),
      .I_St      (I_St),
      .I_Base    (I_Base),
      .I_Len     (I_Len),
      .I_Stride  (I_Stride),
      .I_Stall   (I_Stall),
      .O_Grant   (O_Grant),
      .O_Mem_En  (O_Mem_En),
      .O_Mem_We  (O_Mem_We),
      .O_Mem_Addr(O_Mem_Addr),
      .O_Ld_Valid(O_Ld_Valid),
      .O_Done    (O_Done),
      .O_Busy    (O_Busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [2:0] g, input logic en, input logic we,
                             input logic [9:0] addr, input logic chk_addr, input logic [2:0] ldv,
                             input logic [2:0] done, input logic busy);
      check_eq({tag, " grant"}, 32'(O_Grant), 32'(g));
      check_eq({tag, " en"}, 32'(O_Mem_En), 32'(en));
      check_eq({tag, " we"}, 32'(O_Mem_We), 32'(we));
      if (chk_addr) check_eq({tag, " addr"}, 32'(O_Mem_Addr), 32'(addr));
      check_eq({tag, " ldv"}, 32'(O_Ld_Valid), 32'(ldv));
      check_eq({tag, " done"}, 32'(O_Done), 32'(done));
      check_eq({tag, " busy"}, 32'(O_Busy), 32'(busy));
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      I_Req    = '0;
      I_St     = '0;
      I_Base   = '0;
      I_Len    = '0;
      I_Stride = '0;
      I_Stall  = 1'b0;
   endtask

   task automatic load_req(input int idx, input logic st, input logic [9:0] base,
                           input logic [7:0] len, input logic [9:0] stride);
      I_St[idx]                     = st;
      I_Base[idx*ADDR_W +: ADDR_W]   = base;
      I_Len[idx*LEN_W +: LEN_W]      = len;
      I_Stride[idx*ADDR_W +: ADDR_W] = stride;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int n;
      int cyc;
      logic [2:0] req_v;
      logic en;

      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int cyc;
      logic [2:0] req_v;
      logic en;

      // Reset state
      do_reset();
      @(negedge clock);
      check_outs("reset", 3'b000, 1'b0, 1'b0, 10'h000, 1'b1, 3'b000, 3'b000, 1'b0);
      next_cycle();

      // Load, base 0x010, len 4, stride 1 on req0
      do_reset();
      for (int c = 0; c <= 8; c++) begin
         I_Req = (c == 0) ? 3'b001 : 3'b000;
         if (c == 0) load_req(0, 1'b0, 10'h010, 8'd4, 10'd1);
         @(negedge clock);
         check_outs($sformatf("t1 c%0d", c), (c >= 1 && c <= 7) ? 3'b001 : 3'b000,
                    (c >= 1 && c <= 4), 1'b0, 10'(32'h010 + c - 1), (c >= 1 && c <= 4),
                    (c >= 3 && c <= 6) ? 3'b001 : 3'b000, (c == 7) ? 3'b001 : 3'b000,
                    (c >= 1 && c <= 7));
         next_cycle();
      end

      // Store on req1 with address wrap
      do_reset();
      for (int c = 0; c <= 6; c++) begin
         I_Req = (c == 0) ? 3'b010 : 3'b000;
         if (c == 0) load_req(1, 1'b1, 10'h3FE, 8'd4, 10'd1);
         @(negedge clock);
         check_outs($sformatf("t2 c%0d", c), (c >= 1 && c <= 5) ? 3'b010 : 3'b000,
                    (c >= 1 && c <= 4), (c >= 1 && c <= 4), 10'(32'h3FE + c - 1),
                    (c >= 1 && c <= 4), 3'b000, (c == 5) ? 3'b010 : 3'b000, (c >= 1 && c <= 5));
         next_cycle();
      end

      // Store on req2, stride 2, stall in cycle 2
      do_reset();
      for (int c = 0; c <= 6; c++) begin
         I_Req   = (c == 0) ? 3'b100 : 3'b000;
         I_Stall = (c == 2);
         if (c == 0) load_req(2, 1'b1, 10'h020, 8'd3, 10'd2);
         en = (c == 1 || c == 3 || c == 4);
         @(negedge clock);
         check_outs($sformatf("t3 c%0d", c), (c >= 1 && c <= 5) ? 3'b100 : 3'b000,
                    en, en, t3_addr[(c >= 1 && c <= 4) ? c : 0], (c >= 1 && c <= 4),
                    3'b000, (c == 5) ? 3'b100 : 3'b000, (c >= 1 && c <= 5));
         next_cycle();
      end
      I_Stall = 1'b0;

      // Round robin with all three requesting
      do_reset();
      load_req(0, 1'b1, 10'h040, 8'd1, 10'd1);
      load_req(1, 1'b1, 10'h080, 8'd1, 10'd1);
      load_req(2, 1'b1, 10'h0C0, 8'd1, 10'd1);
      req_v = 3'b111;
      n = 0;
      cyc = 0;
      while (n < 3 && cyc < 60) begin
         I_Req = req_v;
         @(negedge clock);
         if (O_Done != 3'b000) begin
            check_eq($sformatf("rr order %0d", n), 32'(O_Done), 32'(order_exp[n]));
            req_v = req_v & ~O_Done;
            n++;
         end
         next_cycle();
         cyc++;
      end
      check_eq("rr bursts", 32'(n), 32'd3);
      I_Req = 3'b011;
      @(negedge clock);
      check_eq("rr idle bubble busy", 32'(O_Busy), 32'd0);
      next_cycle();
      I_Req = 3'b000;
      @(negedge clock);
      check_eq("rr wrap grant", 32'(O_Grant), 32'(3'b001));
      next_cycle();

      // Zero-length load on req0
      do_reset();
      for (int c = 0; c <= 4; c++) begin
         I_Req = (c == 0) ? 3'b001 : 3'b000;
         if (c == 0) load_req(0, 1'b0, 10'h155, 8'd0, 10'd1);
         @(negedge clock);
         check_outs($sformatf("t5 c%0d", c), (c >= 1 && c <= 2) ? 3'b001 : 3'b000,
                    1'b0, 1'b0, 10'h000, 1'b0, 3'b000, (c == 2) ? 3'b001 : 3'b000,
                    (c >= 1 && c <= 2));
         next_cycle();
      end

      // Reset in cycle 3 of a len 8 load on req1
      do_reset();
      for (int c = 0; c <= 9; c++) begin
         I_Req = (c == 0) ? 3'b010 : ((c == 8) ? 3'b011 : 3'b000);
         reset = (c == 3);
         if (c == 0) load_req(1, 1'b0, 10'h100, 8'd8, 10'd1);
         @(negedge clock);
         if (c >= 1 && c <= 3) begin
            check_eq($sformatf("t6 c%0d grant", c), 32'(O_Grant), 32'(3'b010));
            check_eq($sformatf("t6 c%0d en", c), 32'(O_Mem_En), 32'd1);
         end
         if (c >= 4 && c <= 8) begin
            check_outs($sformatf("t6 c%0d", c), 3'b000, 1'b0, 1'b0, 10'h000, 1'b1,
                       3'b000, 3'b000, 1'b0);
         end
         if (c == 9) begin
            check_eq("t6 post-reset grant", 32'(O_Grant), 32'(3'b001));
         end
         next_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
